crc_frame_engine: RTL and testbench
===================================

Name: crc_frame_engine

Overview:
- Parametrised, frame-aware CRC engine; successor to the fixed 8-bit-in / CRC-5 LFSR checker.
- Generalised in CRC width, polynomial, init value, data width, bit order and final XOR.
- Adds valid/ready handshakes, SOF/EOF framing, a beat-length counter, residue check and protocol-error flagging.
- Sits between a byte/word stream source and the link framer/deframer.
- Generates the CRC on TX and checks it on RX.

Parameters:
- CRC_W, 5: CRC register width (1..32).
- DATA_W, 8: input beat width (1..64).
- POLY, 5'h05: generator polynomial, implicit top term omitted.
- INIT, all ones: CRC register value at SOF.
- XOROUT, 0: XORed into the register to form out_crc.
- RESIDUE, 0: register value that indicates a good frame when the CRC is appended (before XOROUT).
- LSB_FIRST, 0: 0 = in_data processed MSB first; 1 = LSB first.
- LEN_W, 16: width of the beat counter.

Ports:
- ck  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- clr  in  1  synchronous abort; drops the current frame.
- in_valid  in  1  input beat valid.
- in_ready  out  1  engine can accept a beat.
- in_data  in  DATA_W  beat payload.
- in_sof  in  1  first beat of frame.
- in_eof  in  1  last beat of frame.
- out_valid  out  1  result valid.
- out_ready  in  1  result consumer ready.
- out_crc  out  CRC_W  register ^ XOROUT.
- out_ok  out  1  register == RESIDUE.
- out_len  out  LEN_W  accepted beats in frame, saturating.
- err  out  1  one-cycle pulse on a protocol error.

Behaviour:
- Serial step definition, applied to each of the DATA_W bits in the order set by LSB_FIRST:
  - fb = crc[CRC_W-1] ^ d
  - crc = (crc << 1) truncated to CRC_W ^ (fb ? POLY : 0)
- A full beat is DATA_W chained steps, computed combinationally and registered in one cycle.
- Beat accept = in_valid & in_ready.
- in_ready = (state != HOLD); it is a function of registered state only.
- FSM states and transitions:
  - IDLE
    - Accepted beat with sof: crc = beat(INIT, data); len = 1.
    - Then go to HOLD if eof is also set, otherwise RUN.
    - Accepted beat without sof: beat is discarded, err pulses, state stays IDLE.
  - RUN
    - Accepted beat without sof: crc = beat(crc, data); len += 1, saturating at 2^LEN_W-1.
    - eof on that beat: go to HOLD.
    - Accepted beat with sof: err pulses, frame restarts (crc = beat(INIT, data), len = 1); eof on that beat goes to HOLD.
  - HOLD
    - out_valid = 1; out_crc, out_ok and out_len are held stable.
    - out_valid & out_ready: go to IDLE.
    - out_valid stays high until the handshake completes; there is no timeout.
- Latency: out_valid rises on the first ck edge after the EOF beat is accepted.
- Throughput: one beat per cycle inside a frame, plus a minimum of one HOLD cycle per frame.
- out_crc and out_ok are registered (or derived only from registered state); they are undefined-free and 0 outside HOLD.
- clr has the highest priority:
  - Next state is IDLE; out_valid = 0; crc = INIT; len = 0; no err pulse.
  - A beat presented in the same cycle as clr is not consumed, even though in_ready may be 1.
- rst_n low, asynchronous, gives:
  - state = IDLE, crc = INIT, out_valid = 0, out_crc = 0, out_ok = 0, out_len = 0, err = 0.
  - in_ready = 1 once rst_n deasserts.
- Reset or clr during RUN or HOLD discards the frame with no output.
- err is a registered pulse, high for exactly one cycle per offending beat.

Test Plan:
- CRC_W=8, POLY=8'h07, INIT=0, MSB first, DATA_W=8; single-beat frame 0x01 with sof and eof -> out_crc=0x07 one cycle later, out_len=1.
- Same configuration, single beat 0x80 -> out_crc=0x89; with out_ready held low for 5 cycles -> out_valid and out_crc stable, in_ready=0 for all 5 cycles.
- Same configuration, ASCII "123456789" (9 beats, back-to-back) -> out_crc=0xF4, out_len=9; then frame "123456789" followed by 0xF4 -> out_ok=1, out_crc=0x00, out_len=10.
- Defaults (CRC-5): beat without sof in IDLE -> err pulses one cycle, no output; sof mid-frame -> err pulses, and the result equals that of a frame starting at the second sof.
- Defaults: assert clr, and separately rst_n, during RUN and during HOLD -> out_valid=0 next cycle, nothing is emitted, and the next frame's CRC matches a reference model starting from INIT=5'h1F.
- Randomised stimulus (random valid, sof/eof, ready) against a bit-serial software model, for CRC_W/DATA_W/LSB_FIRST combinations (5/8/0, 16/8/1, 32/32/1) -> out_crc and out_len match for every frame.

Source files
------------

// File: rtl/crc_frame_engine.sv
// Frame-aware parametrised CRC engine: SOF/EOF framing, beat counter,
// residue check, protocol-error pulse, valid/ready on both sides.
// Ports: ck, rst_n, clr | in_valid/in_ready/in_data/in_sof/in_eof |
//        out_valid/out_ready/out_crc/out_ok/out_len | err
module crc_frame_engine #(
   parameter int unsigned          CRC_W     = 5,
   parameter int unsigned          DATA_W    = 8,
   parameter logic [CRC_W-1:0]     POLY      = 5'h05,
   parameter logic [CRC_W-1:0]     INIT      = '1,
   parameter logic [CRC_W-1:0]     XOROUT    = '0,
   parameter logic [CRC_W-1:0]     RESIDUE   = '0,
   parameter bit                   LSB_FIRST = 1'b0,
   parameter int unsigned          LEN_W     = 16
) (
   input  logic              ck,
   input  logic              rst_n,
   input  logic              clr,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_sof,
   input  logic              in_eof,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CRC_W-1:0]  out_crc,
   output logic              out_ok,
   output logic [LEN_W-1:0]  out_len,
   output logic              err
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_HOLD = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_next;
   logic [CRC_W-1:0] r_crc;
   logic [CRC_W-1:0] w_crc_nxt;
   logic [CRC_W-1:0] w_beat_in;
   logic [CRC_W-1:0] w_beat_out;
   logic [LEN_W-1:0] r_len;
   logic [LEN_W-1:0] w_len_nxt;
   logic             r_err;
   logic             w_err_nxt;
   logic             w_accept;

   // DATA_W chained serial LFSR steps, unrolled into one combinational beat
   function automatic logic [CRC_W-1:0] f_beat(
      input logic [CRC_W-1:0]  c_in,
      input logic [DATA_W-1:0] d
   );
      logic [CRC_W-1:0] c;
      logic             b;
      logic             fb;
      c = c_in;
      for (int i = 0; i < int'(DATA_W); i++) begin
         b  = LSB_FIRST ? d[i] : d[int'(DATA_W)-1-i];
         fb = c[CRC_W-1] ^ b;
         c  = c << 1;
         if (fb) c = c ^ POLY;
      end
      return c;
   endfunction

   // clr blocks consumption even while in_ready is high
   assign w_accept   = in_valid & in_ready & ~clr;
   // SOF always restarts from INIT, whether in IDLE or mid-frame
   assign w_beat_in  = in_sof ? INIT : r_crc;
   assign w_beat_out = f_beat(w_beat_in, in_data);

   always_ff @(posedge ck or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      if (clr) begin
         w_next = ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_accept && in_sof)
                  w_next = in_eof ? ST_HOLD : ST_RUN;
            end
            ST_RUN: begin
               if (w_accept)
                  w_next = in_eof ? ST_HOLD : ST_RUN;
            end
            ST_HOLD: begin
               if (out_ready) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      in_ready  = (r_state != ST_HOLD);
      out_valid = (r_state == ST_HOLD);
      out_crc   = out_valid ? (r_crc ^ XOROUT) : '0;
      out_ok    = out_valid && (r_crc == RESIDUE);
      out_len   = out_valid ? r_len : '0;
      err       = r_err;
   end

   always_comb begin
      w_crc_nxt = r_crc;
      w_len_nxt = r_len;
      w_err_nxt = 1'b0;
      if (clr) begin
         w_crc_nxt = INIT;
         w_len_nxt = '0;
      end else if (w_accept) begin
         if (in_sof) begin
            w_crc_nxt = w_beat_out;
            w_len_nxt = LEN_W'(1);
            w_err_nxt = (r_state == ST_RUN);
         end else if (r_state == ST_RUN) begin
            w_crc_nxt = w_beat_out;
            if (r_len != '1) w_len_nxt = r_len + LEN_W'(1);
         end else begin
            // data beat with no open frame
            w_err_nxt = 1'b1;
         end
      end
   end

   always_ff @(posedge ck or negedge rst_n) begin
      if (!rst_n) begin
         r_crc <= INIT;
         r_len <= '0;
         r_err <= 1'b0;
      end else begin
         r_crc <= w_crc_nxt;
         r_len <= w_len_nxt;
         r_err <= w_err_nxt;
      end
   end

endmodule

// File: tb/tb_crc_frame_engine.sv
// Self-checking bench for crc_frame_engine: four configurations,
// directed framing/abort cases and randomised frames vs a reference model.
module tb_crc_frame_engine;

   localparam int          CW   [4] = '{8, 5, 16, 32};
   localparam int          DW   [4] = '{8, 8, 8, 32};
   localparam logic [31:0] PL   [4] = '{32'h07, 32'h05, 32'h8005, 32'h04C11DB7};
   localparam logic [31:0] IV   [4] = '{32'h0, 32'h1F, 32'hFFFF, 32'hFFFFFFFF};
   localparam logic [31:0] XO   [4] = '{32'h0, 32'h0, 32'h0, 32'hFFFFFFFF};
   localparam bit          LF   [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
   localparam int          LMAX [4] = '{65535, 65535, 7, 65535};

   logic        ck;
   logic        rst_n;
   logic [3:0]  clr, vld, sof, eof, ordy;
   logic [3:0]  rdy, ov, ok, er;
   logic [31:0] din;
   logic [7:0]  cA;
   logic [4:0]  cB;
   logic [15:0] cC;
   logic [31:0] cD;
   logic [15:0] lA, lB, lD;
   logic [2:0]  lC;

   int checks = 0;
   int failures = 0;

   crc_frame_engine #(
      .CRC_W(8), .DATA_W(8), .POLY(8'h07), .INIT(8'h00),
      .XOROUT(8'h00), .RESIDUE(8'h00), .LSB_FIRST(1'b0), .LEN_W(16)
   ) u_a (
      .ck(ck), .rst_n(rst_n), .clr(clr[0]),
      .in_valid(vld[0]), .in_ready(rdy[0]), .in_data(din[7:0]),
      .in_sof(sof[0]), .in_eof(eof[0]),
      .out_valid(ov[0]), .out_ready(ordy[0]),
      .out_crc(cA), .out_ok(ok[0]), .out_len(lA), .err(er[0])
   );

   crc_frame_engine u_b (
      .ck(ck), .rst_n(rst_n), .clr(clr[1]),
      .in_valid(vld[1]), .in_ready(rdy[1]), .in_data(din[7:0]),
      .in_sof(sof[1]), .in_eof(eof[1]),
      .out_valid(ov[1]), .out_ready(ordy[1]),
      .out_crc(cB), .out_ok(ok[1]), .out_len(lB), .err(er[1])
   );

   crc_frame_engine #(
      .CRC_W(16), .DATA_W(8), .POLY(16'h8005), .INIT(16'hFFFF),
      .XOROUT(16'h0000), .RESIDUE(16'h0000), .LSB_FIRST(1'b1), .LEN_W(3)
   ) u_c (
      .ck(ck), .rst_n(rst_n), .clr(clr[2]),
      .in_valid(vld[2]), .in_ready(rdy[2]), .in_data(din[7:0]),
      .in_sof(sof[2]), .in_eof(eof[2]),
      .out_valid(ov[2]), .out_ready(ordy[2]),
      .out_crc(cC), .out_ok(ok[2]), .out_len(lC), .err(er[2])
   );

   crc_frame_engine #(
      .CRC_W(32), .DATA_W(32), .POLY(32'h04C11DB7), .INIT(32'hFFFFFFFF),
      .XOROUT(32'hFFFFFFFF), .RESIDUE(32'h0), .LSB_FIRST(1'b1), .LEN_W(16)
   ) u_d (
      .ck(ck), .rst_n(rst_n), .clr(clr[3]),
      .in_valid(vld[3]), .in_ready(rdy[3]), .in_data(din),
      .in_sof(sof[3]), .in_eof(eof[3]),
      .out_valid(ov[3]), .out_ready(ordy[3]),
      .out_crc(cD), .out_ok(ok[3]), .out_len(lD), .err(er[3])
   );

   initial ck = 1'b0;
   always #5 ck = ~ck;

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   function automatic logic [63:0] crc_of(int k);
      case (k)
         0:       return 64'(cA);
         1:       return 64'(cB);
         2:       return 64'(cC);
         default: return 64'(cD);
      endcase
   endfunction

   function automatic logic [63:0] len_of(int k);
      case (k)
         0:       return 64'(lA);
         1:       return 64'(lB);
         2:       return 64'(lC);
         default: return 64'(lD);
      endcase
   endfunction

   // Polynomial division over the frame bit stream, one bit at a time
   function automatic logic [63:0] model_crc(int k, logic [31:0] q[$]);
      longint unsigned c;
      longint unsigned mask;
      longint unsigned b;
      longint unsigned top;
      mask = (64'd1 << CW[k]) - 64'd1;
      c = 64'(IV[k]);
      foreach (q[j]) begin
         for (int i = 0; i < DW[k]; i++) begin
            if (LF[k]) b = (64'(q[j]) >> i) & 64'd1;
            else       b = (64'(q[j]) >> (DW[k] - 1 - i)) & 64'd1;
            top = (c >> (CW[k] - 1)) & 64'd1;
            c = (c << 1) & mask;
            if ((top ^ b) != 64'd0) c = c ^ 64'(PL[k]);
         end
      end
      return (c ^ 64'(XO[k])) & mask;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge ck);
      #1;
   endtask

   task automatic beat(int k, logic [31:0] d, bit s, bit e);
      din    = d;
      sof[k] = s;
      eof[k] = e;
      vld[k] = 1'b1;
      step();
      vld[k] = 1'b0;
      sof[k] = 1'b0;
      eof[k] = 1'b0;
   endtask

   task automatic send_frame(int k, logic [31:0] q[$], bit gaps);
      foreach (q[i]) begin
         while (gaps && ($urandom_range(0, 2) == 0)) step();
         beat(k, q[i], (i == 0), (i == q.size() - 1));
      end
   endtask

   initial begin
      logic [31:0] q[$];
      logic [63:0] exp;
      logic [31:0] mask;
      bit          r;
      int          n;
      int          t;

      rst_n = 1'b0;
      clr   = '0;
      vld   = '0;
      sof   = '0;
      eof   = '0;
      ordy  = '1;
      din   = '0;

      // reset state
      #12;
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("rst_ov%0d", k), 64'(ov[k]), 64'd0);
         chk($sformatf("rst_crc%0d", k), crc_of(k), 64'd0);
         chk($sformatf("rst_ok%0d", k), 64'(ok[k]), 64'd0);
         chk($sformatf("rst_len%0d", k), len_of(k), 64'd0);
         chk($sformatf("rst_err%0d", k), 64'(er[k]), 64'd0);
      end
      rst_n = 1'b1;
      step();
      for (int k = 0; k < 4; k++)
         chk($sformatf("rst_rdy%0d", k), 64'(rdy[k]), 64'd1);

      // CRC-8/0x07: single beat 0x01
      q = '{32'h01};
      send_frame(0, q, 1'b0);
      chk("a01_ov", 64'(ov[0]), 64'd1);
      chk("a01_crc", crc_of(0), 64'h07);
      chk("a01_len", len_of(0), 64'd1);
      chk("a01_ok", 64'(ok[0]), 64'd0);
      step();
      chk("a01_drain", 64'(ov[0]), 64'd0);
      chk("a01_rdy", 64'(rdy[0]), 64'd1);

      // single beat 0x80 with consumer stalled
      ordy[0] = 1'b0;
      q = '{32'h80};
      send_frame(0, q, 1'b0);
      for (int i = 0; i < 5; i++) begin
         chk("a80_ov", 64'(ov[0]), 64'd1);
         chk("a80_crc", crc_of(0), 64'h89);
         chk("a80_rdy", 64'(rdy[0]), 64'd0);
         step();
      end
      ordy[0] = 1'b1;
      step();
      chk("a80_drain", 64'(ov[0]), 64'd0);

      // "123456789" check value, then residue with appended CRC
      q = '{32'h31, 32'h32, 32'h33, 32'h34, 32'h35,
            32'h36, 32'h37, 32'h38, 32'h39};
      send_frame(0, q, 1'b0);
      chk("chk_crc", crc_of(0), 64'hF4);
      chk("chk_len", len_of(0), 64'd9);
      chk("chk_ok", 64'(ok[0]), 64'd0);
      step();
      q.push_back(32'hF4);
      send_frame(0, q, 1'b0);
      chk("res_ok", 64'(ok[0]), 64'd1);
      chk("res_crc", crc_of(0), 64'h00);
      chk("res_len", len_of(0), 64'd10);
      step();

      // CRC-5 defaults: beat without SOF in IDLE
      beat(1, 32'h05, 1'b0, 1'b1);
      chk("nosof_err", 64'(er[1]), 64'd1);
      chk("nosof_ov", 64'(ov[1]), 64'd0);
      step();
      chk("nosof_err_clr", 64'(er[1]), 64'd0);
      chk("nosof_ov2", 64'(ov[1]), 64'd0);

      // SOF mid-frame restarts the frame
      beat(1, 32'hAA, 1'b1, 1'b0);
      chk("rs_err0", 64'(er[1]), 64'd0);
      beat(1, 32'h3C, 1'b0, 1'b0);
      beat(1, 32'h5A, 1'b1, 1'b0);
      chk("rs_err1", 64'(er[1]), 64'd1);
      beat(1, 32'hC3, 1'b0, 1'b1);
      chk("rs_err2", 64'(er[1]), 64'd0);
      chk("rs_ov", 64'(ov[1]), 64'd1);
      q = '{32'h5A, 32'hC3};
      chk("rs_crc", crc_of(1), model_crc(1, q));
      chk("rs_len", len_of(1), 64'd2);
      step();

      // clr during RUN
      beat(1, 32'h11, 1'b1, 1'b0);
      clr[1] = 1'b1;
      step();
      clr[1] = 1'b0;
      chk("clrrun_ov", 64'(ov[1]), 64'd0);
      step();
      chk("clrrun_ov2", 64'(ov[1]), 64'd0);
      q = '{32'h22, 32'h33};
      send_frame(1, q, 1'b0);
      chk("clrrun_crc", crc_of(1), model_crc(1, q));
      chk("clrrun_len", len_of(1), 64'd2);
      step();

      // clr during HOLD
      ordy[1] = 1'b0;
      q = '{32'h44};
      send_frame(1, q, 1'b0);
      chk("clrhold_ov1", 64'(ov[1]), 64'd1);
      clr[1] = 1'b1;
      step();
      clr[1] = 1'b0;
      chk("clrhold_ov0", 64'(ov[1]), 64'd0);
      chk("clrhold_err", 64'(er[1]), 64'd0);
      ordy[1] = 1'b1;
      step();
      chk("clrhold_ov2", 64'(ov[1]), 64'd0);

      // beat coincident with clr is dropped
      clr[1] = 1'b1;
      beat(1, 32'h55, 1'b1, 1'b1);
      clr[1] = 1'b0;
      chk("clrbeat_ov", 64'(ov[1]), 64'd0);
      chk("clrbeat_err", 64'(er[1]), 64'd0);
      step();
      chk("clrbeat_ov2", 64'(ov[1]), 64'd0);
      q = '{32'h66};
      send_frame(1, q, 1'b0);
      chk("clrbeat_crc", crc_of(1), model_crc(1, q));
      chk("clrbeat_len", len_of(1), 64'd1);
      step();

      // async reset during RUN
      beat(1, 32'h77, 1'b1, 1'b0);
      rst_n = 1'b0;
      #2;
      chk("rstrun_ov", 64'(ov[1]), 64'd0);
      rst_n = 1'b1;
      step();
      chk("rstrun_ov2", 64'(ov[1]), 64'd0);
      q = '{32'h12, 32'h34};
      send_frame(1, q, 1'b0);
      chk("rstrun_crc", crc_of(1), model_crc(1, q));
      chk("rstrun_len", len_of(1), 64'd2);
      step();

      // async reset during HOLD
      ordy[1] = 1'b0;
      q = '{32'h09};
      send_frame(1, q, 1'b0);
      chk("rsthold_ov1", 64'(ov[1]), 64'd1);
      rst_n = 1'b0;
      #2;
      chk("rsthold_ov0", 64'(ov[1]), 64'd0);
      chk("rsthold_crc", crc_of(1), 64'd0);
      chk("rsthold_len", len_of(1), 64'd0);
      rst_n = 1'b1;
      ordy[1] = 1'b1;
      step();
      chk("rsthold_ov2", 64'(ov[1]), 64'd0);
      q = '{32'hE7, 32'h18, 32'hFF};
      send_frame(1, q, 1'b0);
      chk("rsthold_crc2", crc_of(1), model_crc(1, q));
      chk("rsthold_len2", len_of(1), 64'd3);
      step();

      // randomised frames on CRC-5, CRC-16 LSB-first, CRC-32 LSB-first
      for (int k = 1; k < 4; k++) begin
         mask = (DW[k] == 32) ? 32'hFFFFFFFF : 32'h000000FF;
         for (int f = 0; f < 12; f++) begin
            n = $urandom_range(1, 10);
            q = {};
            for (int i = 0; i < n; i++) q.push_back($urandom() & mask);
            ordy[k] = 1'($urandom_range(0, 1));
            send_frame(k, q, 1'b1);
            exp = model_crc(k, q);
            chk($sformatf("rnd%0d_ov", k), 64'(ov[k]), 64'd1);
            chk($sformatf("rnd%0d_crc", k), crc_of(k), exp);
            chk($sformatf("rnd%0d_len", k), len_of(k),
                64'((n < LMAX[k]) ? n : LMAX[k]));
            chk($sformatf("rnd%0d_ok", k), 64'(ok[k]),
                64'(((exp ^ 64'(XO[k])) == 64'd0) ? 1 : 0));
            t = 0;
            r = 1'b0;
            while (!r) begin
               r = (t >= 20) ? 1'b1 : 1'($urandom_range(0, 1));
               ordy[k] = r;
               step();
               t++;
               if (!r) chk($sformatf("rnd%0d_hold", k), crc_of(k), exp);
            end
            chk($sformatf("rnd%0d_drain", k), 64'(ov[k]), 64'd0);
         end
         ordy[k] = 1'b1;
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
